demo_run_ctrl: RTL

Scheduler that shares one `demo` counter instance among NREQ requesters. Each request asks to run the counter for a given number of enabled cycles. The controller grants requests round-robin, clears the counter, gates `enable` for exactly the requested length, then returns the final `out` value tagged with the requester id. It sits between the requesters and `demo`, and directly drives `demo`'s reset and enable pins.

---
 rtl/demo_run_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/demo_run_ctrl.sv
// demo_run_ctrl
//   Shares one `demo` counter among NREQ requesters. Requests are granted
//   round-robin; for each grant the counter is cleared, enabled for exactly
//   the requested number of cycles, and its final value is returned tagged
//   with the requester id.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   req_valid[NREQ]   per-requester run request
//   req_len           packed run lengths, requester i at [i*LENW +: LENW]
//   req_ready[NREQ]   one-hot grant (only ever high in IDLE)
//   cnt_reset         drives demo.reset (also follows the block reset)
//   cnt_enable        drives demo.enable
//   cnt_out           demo.out
//   rsp_valid/rsp_ready, rsp_id, rsp_data   result channel
//   busy              high whenever the controller is not idle
//   state_dbg         current FSM state encoding
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid may be withdrawn before it is granted; rsp_valid,
// once raised, stays high with rsp_id/rsp_data stable until rsp_ready.

module demo_run_ctrl #(
    parameter int NREQ = 4,
    parameter int LENW = 8,
    parameter int OUTW = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cnt_reset,
    output logic                 cnt_enable,
    input  logic [OUTW-1:0]      cnt_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [OUTW-1:0]      rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [LENW-1:0] rem;

    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant_onehot;

    // Round-robin pick: first valid requester scanning from ptr+1 upward,
    // wrapping, so the most recently served requester has lowest priority.
    always_comb begin
        grant_any    = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
        if (grant_any) begin
            grant_onehot = NREQ'(1) << grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            id_q     <= '0;
            rem      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rem  <= req_len[grant_id*LENW +: LENW];
                        id_q <= grant_id;
                        ptr  <= grant_id;
                    end
                end
                RUN: begin
                    rem <= rem - LENW'(1);
                end
                SAMPLE: begin
                    // The counter output is registered, so by SAMPLE it
                    // already reflects the last enabled RUN cycle.
                    rsp_data <= cnt_out;
                    rsp_id   <= id_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        cnt_enable = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant_onehot;
                if (grant_any) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                // A zero-length run skips RUN and returns the cleared value.
                state_next = (rem != '0) ? RUN : SAMPLE;
            end
            RUN: begin
                cnt_enable = 1'b1;
                if (rem == LENW'(1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The counter is cleared alongside the controller on block reset.
    assign cnt_reset = reset | (state == CLEAR);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
